// File: rtl/aes256_dec_fsm_if.sv
// AES-256 decryptor request/result bundle.
// master drives the block request, slave returns plaintext and status.
interface aes256_dec_fsm_if;
  logic         Start;
  logic [127:0] Cipher_text_T;
  logic [255:0] In_Key_T;
  logic [127:0] Plain_text_T;
  logic [127:0] Plain_text_F;
  logic         Done;
  logic         Busy;
  logic         trigger;

  modport master (
    output Start,
    output Cipher_text_T,
    output In_Key_T,
    input  Plain_text_T,
    input  Plain_text_F,
    input  Done,
    input  Busy,
    input  trigger
  );

  modport slave (
    input  Start,
    input  Cipher_text_T,
    input  In_Key_T,
    output Plain_text_T,
    output Plain_text_F,
    output Done,
    output Busy,
    output trigger
  );
endinterface

// File: rtl/aes256_dec_fsm.sv
// Iterative AES-256 decryptor, one round per clock.
// Round keys run forward to w52..w59, then step backward each round.
module aes256_dec_fsm (
  input  logic            Clk,
  input  logic            Reset,
  aes256_dec_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    WHITEN,
    ROUND,
    FINAL
  } state_t;

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 is the field inverse; 0 maps to 0
  function automatic logic [7:0] gf_inv(
    input logic [7:0] x
  );
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), x);
    end
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] x
  );
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]}
             ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(
    input logic [7:0] x
  );
    logic [7:0] v;
    v = {x[6:0], x[7]} ^ {x[4:0], x[7:5]}
      ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(v);
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  // row r rotates right by r columns
  function automatic logic [127:0] inv_shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    int           src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = (c - r + 4) % 4;
        o[127 - 8*(r + 4*c) -: 8] =
          s[127 - 8*(r + 4*src) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      o[127 - 8*n -: 8] = inv_sbox(s[127 - 8*n -: 8]);
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(
    input logic [31:0] col
  );
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
       ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    b1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
       ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    b2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
       ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    b3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
       ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [127:0] inv_mix_columns(
    input logic [127:0] s
  );
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
  endfunction

  state_t       state_q, state_d;
  logic [3:0]   kcnt_q, kcnt_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] s_q, s_d;
  logic [255:0] w_q, w_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] pf_q, pf_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic         trig_q, trig_d;

  logic [31:0]  wv [8];
  logic [3:0]   g_cnt;
  logic         g_rot;
  logic [31:0]  g_in;
  logic [7:0]   g_rc;
  logic [31:0]  g_out;
  logic [31:0]  n0, n1, n2, n3;
  logic [31:0]  b0, b1, b2, b3;
  logic [255:0] w_fwd, w_bwd;
  logic [127:0] isr, final_out, round_out;

  // Key window g-transform, forward/backward steps and round datapath.
  // KEYEXP feeds g with w[i-1] = W[7]; ROUND feeds it W[3] = w[j-1].
  // Rcon index i/8 (or j/8) works out to cnt[3:1]+1 in both directions.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      wv[k] = w_q[255 - 32*k -: 32];
    end
    g_cnt = (state_q == ROUND) ? rnd_q : kcnt_q;
    g_rot = (state_q == ROUND) ? rnd_q[0] : ~kcnt_q[0];
    g_in  = (state_q == ROUND) ? wv[3] : wv[7];
    g_rc  = 8'h01 << g_cnt[3:1];
    if (g_rot) begin
      g_out = sub_word({g_in[23:0], g_in[31:24]})
            ^ {g_rc, 24'h0};
    end else begin
      g_out = sub_word(g_in);
    end
    n0 = wv[0] ^ g_out;
    n1 = wv[1] ^ n0;
    n2 = wv[2] ^ n1;
    n3 = wv[3] ^ n2;
    w_fwd = {wv[4], wv[5], wv[6], wv[7], n0, n1, n2, n3};
    b3 = wv[7] ^ wv[6];
    b2 = wv[6] ^ wv[5];
    b1 = wv[5] ^ wv[4];
    b0 = wv[4] ^ g_out;
    w_bwd = {b0, b1, b2, b3, wv[0], wv[1], wv[2], wv[3]};
    isr       = inv_sub_bytes(inv_shift_rows(s_q));
    final_out = isr ^ w_q[255:128];
    round_out = inv_mix_columns(final_out);
  end

  // Next-state and registered-output logic for the round sequencer.
  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    rnd_d   = rnd_q;
    s_d     = s_q;
    w_d     = w_q;
    pt_d    = pt_q;
    pf_d    = pf_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    trig_d  = trig_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          s_d     = bus.Cipher_text_T;
          w_d     = bus.In_Key_T;
          kcnt_d  = 4'd0;
          busy_d  = 1'b1;
          trig_d  = 1'b1;
          state_d = KEYEXP;
        end
      end
      KEYEXP: begin
        w_d    = w_fwd;
        kcnt_d = kcnt_q + 4'd1;
        if (kcnt_q == 4'd12) state_d = WHITEN;
      end
      WHITEN: begin
        s_d     = s_q ^ w_q[127:0];
        rnd_d   = 4'd13;
        state_d = ROUND;
      end
      ROUND: begin
        s_d   = round_out;
        w_d   = w_bwd;
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) state_d = FINAL;
      end
      FINAL: begin
        pt_d    = final_out;
        pf_d    = ~final_out;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        trig_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      kcnt_q  <= '0;
      rnd_q   <= '0;
      s_q     <= '0;
      w_q     <= '0;
      pt_q    <= '0;
      pf_q    <= '1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
      rnd_q   <= rnd_d;
      s_q     <= s_d;
      w_q     <= w_d;
      pt_q    <= pt_d;
      pf_q    <= pf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      trig_q  <= trig_d;
    end
  end

  assign bus.Plain_text_T = pt_q;
  assign bus.Plain_text_F = pf_q;
  assign bus.Done         = done_q;
  assign bus.Busy         = busy_q;
  assign bus.trigger      = trig_q;

endmodule

// File: tb/tb_aes256_dec_fsm.sv
// Directed bench for the iterative AES-256 decryptor.
// Known-answer vectors plus a behavioural encryptor for the round trip.
module tb_aes256_dec_fsm;

  logic Clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  aes256_dec_fsm_if ifc ();

  aes256_dec_fsm dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ifc)
  );

  always #5 Clk = ~Clk;

  localparam logic [255:0] K_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] P_C3 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K_SP =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] C_SP1 = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
  localparam logic [127:0] P_SP1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C_SP2 = 128'h591ccb10d410ed26dc5ba74a31362870;
  localparam logic [127:0] P_SP2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C_SP4 = 128'h23304b7a39f9f3ff067d8d8f9e24ecc7;
  localparam logic [127:0] P_SP4 = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] ONES  = '1;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // inverse found by search, then the FIPS-197 affine map
  function automatic logic [7:0] tsbox(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (tmul(x, 8'(y)) == 8'h01) v = 8'(y);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] tsub(input logic [31:0] t);
    return {tsbox(t[31:24]), tsbox(t[23:16]), tsbox(t[15:8]), tsbox(t[7:0])};
  endfunction

  function automatic logic [127:0] enc256(input logic [255:0] key,
                                          input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   b [16];
    logic [7:0]   o [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] s;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = tsub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = tsub(t);
      end
      w[i] = w[i-8] ^ t;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 14; r++) begin
      for (int n = 0; n < 16; n++) b[n] = tsbox(s[127 - 8*n -: 8]);
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          o[q + 4*c] = b[q + 4*((c + q) % 4)];
      if (r < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = o[4*c];
          a1 = o[4*c+1];
          a2 = o[4*c+2];
          a3 = o[4*c+3];
          o[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          o[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          o[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          o[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int n = 0; n < 16; n++) s[127 - 8*n -: 8] = o[n];
      s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Start high across one edge (E0), then low again.
  task automatic start_op(input logic [255:0] k, input logic [127:0] c);
    ifc.In_Key_T      = k;
    ifc.Cipher_text_T = c;
    ifc.Start         = 1'b1;
    tick();
    ifc.Start = 1'b0;
  endtask

  // lat = edges after E0 until Done is seen; 0 if the bound expires.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ifc.Done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    ifc.Start = 1'b0;
    ifc.Cipher_text_T = '0;
    ifc.In_Key_T = '0;
    repeat (3) tick();
    total++;
    if (ifc.Busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b want=0", ifc.Busy);
    end
    total++;
    if (ifc.trigger !== 1'b0) begin
      bad++; $display("FAIL reset_trigger got=%b want=0", ifc.trigger);
    end
    total++;
    if (ifc.Done !== 1'b0) begin
      bad++; $display("FAIL reset_done got=%b want=0", ifc.Done);
    end
    total++;
    if (ifc.Plain_text_T !== 128'h0) begin
      bad++; $display("FAIL reset_pt got=%h want=0", ifc.Plain_text_T);
    end
    total++;
    if (ifc.Plain_text_F !== ONES) begin
      bad++; $display("FAIL reset_pf got=%h want=%h", ifc.Plain_text_F, ONES);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_fips_c3();
    int lat;
    start_op(K_C3, C_C3);
    total++;
    if (ifc.Busy !== 1'b1 || ifc.trigger !== 1'b1) begin
      bad++; $display("FAIL c3_busy_trig got=%b%b want=11", ifc.Busy, ifc.trigger);
    end
    wait_done(lat);
    total++;
    if (lat != 28) begin
      bad++; $display("FAIL c3_latency got=%0d want=28", lat);
    end
    total++;
    if (ifc.Plain_text_T !== P_C3) begin
      bad++; $display("FAIL c3_pt got=%h want=%h", ifc.Plain_text_T, P_C3);
    end
    total++;
    if (ifc.Plain_text_F !== ~P_C3) begin
      bad++; $display("FAIL c3_pf got=%h want=%h", ifc.Plain_text_F, ~P_C3);
    end
    total++;
    if (ifc.Busy !== 1'b0 || ifc.trigger !== 1'b0) begin
      bad++; $display("FAIL c3_idle_in_done got=%b%b want=00", ifc.Busy, ifc.trigger);
    end
    tick();
    total++;
    if (ifc.Done !== 1'b0) begin
      bad++; $display("FAIL c3_done_width got=%b want=0", ifc.Done);
    end
    total++;
    if (ifc.Plain_text_T !== P_C3) begin
      bad++; $display("FAIL c3_pt_hold got=%h want=%h", ifc.Plain_text_T, P_C3);
    end
  endtask

  task automatic test_sp800();
    int lat;
    start_op(K_SP, C_SP1);
    wait_done(lat);
    total++;
    if (lat != 28) begin
      bad++; $display("FAIL sp1_latency got=%0d want=28", lat);
    end
    total++;
    if (ifc.Plain_text_T !== P_SP1) begin
      bad++; $display("FAIL sp1_pt got=%h want=%h", ifc.Plain_text_T, P_SP1);
    end
    tick();
  endtask

  task automatic test_round_trip();
    int lat;
    logic [255:0] k;
    logic [127:0] c;
    k = {128'h00112233445566778899aabbccddeeff,
         128'h00112233445566778899aabbccddeeff};
    c = enc256(k, 128'h0);
    start_op(k, c);
    wait_done(lat);
    total++;
    if (ifc.Plain_text_T !== 128'h0 || lat != 28) begin
      bad++; $display("FAIL rt_pt got=%h lat=%0d want=0 lat=28", ifc.Plain_text_T, lat);
    end
    total++;
    if (ifc.Plain_text_F !== ONES) begin
      bad++; $display("FAIL rt_pf got=%h want=%h", ifc.Plain_text_F, ONES);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    bit held_bad;
    bit early;
    held_bad = 1'b0;
    early    = 1'b0;
    start_op(K_SP, C_SP2);
    wait_done(lat);
    total++;
    if (lat != 28 || ifc.Plain_text_T !== P_SP2) begin
      bad++; $display("FAIL b2b_first got=%h lat=%0d want=%h lat=28",
                      ifc.Plain_text_T, lat, P_SP2);
    end
    start_op(K_SP, C_SP4);
    total++;
    if (ifc.Busy !== 1'b1) begin
      bad++; $display("FAIL b2b_accept got=%b want=1", ifc.Busy);
    end
    for (int i = 1; i <= 27; i++) begin
      tick();
      if (ifc.Plain_text_T !== P_SP2) held_bad = 1'b1;
      if (ifc.Done !== 1'b0) early = 1'b1;
    end
    total++;
    if (held_bad || early) begin
      bad++; $display("FAIL b2b_hold got=held_bad%0d early%0d want=00", held_bad, early);
    end
    tick();
    total++;
    if (ifc.Done !== 1'b1) begin
      bad++; $display("FAIL b2b_done_at_29 got=%b want=1", ifc.Done);
    end
    total++;
    if (ifc.Plain_text_T !== P_SP4) begin
      bad++; $display("FAIL b2b_second got=%h want=%h", ifc.Plain_text_T, P_SP4);
    end
    tick();
  endtask

  task automatic test_ignore_inputs();
    int ndone;
    bit done28;
    logic [127:0] pt28;
    ndone  = 0;
    done28 = 1'b0;
    pt28   = '0;
    start_op(K_C3, C_C3);
    for (int e = 1; e <= 64; e++) begin
      if (e == 5 || e == 20) begin
        ifc.Start = 1'b1;
        ifc.In_Key_T = {8{32'hdeadbeef ^ 32'(e)}};
        ifc.Cipher_text_T = {4{32'h5a5a0000 | 32'(e)}};
      end
      tick();
      ifc.Start = 1'b0;
      if (ifc.Done === 1'b1) ndone++;
      if (e == 28) begin
        done28 = ifc.Done;
        pt28   = ifc.Plain_text_T;
      end
    end
    total++;
    if (ndone != 1) begin
      bad++; $display("FAIL ign_done_count got=%0d want=1", ndone);
    end
    total++;
    if (done28 !== 1'b1) begin
      bad++; $display("FAIL ign_done_at_28 got=%b want=1", done28);
    end
    total++;
    if (pt28 !== P_C3) begin
      bad++; $display("FAIL ign_pt got=%h want=%h", pt28, P_C3);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    int lat;
    ndone = 0;
    start_op(K_SP, C_SP1);
    for (int e = 1; e <= 16; e++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    total++;
    if (ifc.Busy !== 1'b0) begin
      bad++; $display("FAIL mid_busy got=%b want=0", ifc.Busy);
    end
    total++;
    if (ifc.trigger !== 1'b0) begin
      bad++; $display("FAIL mid_trigger got=%b want=0", ifc.trigger);
    end
    total++;
    if (ifc.Plain_text_T !== 128'h0) begin
      bad++; $display("FAIL mid_pt got=%h want=0", ifc.Plain_text_T);
    end
    total++;
    if (ifc.Plain_text_F !== ONES) begin
      bad++; $display("FAIL mid_pf got=%h want=%h", ifc.Plain_text_F, ONES);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ifc.Done === 1'b1) ndone++;
    end
    total++;
    if (ndone != 0) begin
      bad++; $display("FAIL mid_no_done got=%0d want=0", ndone);
    end
    start_op(K_SP, C_SP4);
    wait_done(lat);
    total++;
    if (lat != 28 || ifc.Plain_text_T !== P_SP4) begin
      bad++; $display("FAIL mid_fresh got=%h lat=%0d want=%h lat=28",
                      ifc.Plain_text_T, lat, P_SP4);
    end
    tick();
  endtask

  task automatic test_reset_with_start();
    bit moved;
    int ndone;
    moved = 1'b0;
    ndone = 0;
    Reset = 1'b1;
    ifc.Start = 1'b1;
    ifc.In_Key_T = K_C3;
    ifc.Cipher_text_T = C_C3;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ifc.Busy !== 1'b0 || ifc.trigger !== 1'b0 || ifc.Done !== 1'b0 ||
          ifc.Plain_text_T !== 128'h0 || ifc.Plain_text_F !== ONES)
        moved = 1'b1;
    end
    total++;
    if (moved) begin
      bad++; $display("FAIL rs_held got=outputs_moved want=reset_values pt=%h",
                      ifc.Plain_text_T);
    end
    Reset = 1'b0;
    ifc.Start = 1'b0;
    tick();
    total++;
    if (ifc.Busy !== 1'b0) begin
      bad++; $display("FAIL rs_not_started got=%b want=0", ifc.Busy);
    end
    for (int i = 0; i < 35; i++) begin
      tick();
      if (ifc.Done === 1'b1) ndone++;
    end
    total++;
    if (ndone != 0) begin
      bad++; $display("FAIL rs_no_done got=%0d want=0", ndone);
    end
  endtask

  initial begin
    test_reset();
    test_fips_c3();
    test_sp800();
    test_round_trip();
    test_back_to_back();
    test_ignore_inputs();
    test_reset_mid();
    test_reset_with_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
